// File: rtl/core_ctrl_regfile.sv
// Single-cycle core slice: free-running PC, main control decoder,
// and a 32x32 register file with two async read ports.
module core_ctrl_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic [31:0] wr_data,
    output logic [4:0]  pc,
    output logic [31:0] rd_data1,
    output logic [31:0] rd_data2,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic [2:0]  alu_op,
    output logic        alu_src,
    output logic        reg_write
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  wr_addr;
    logic        wr_en;
    logic [31:0] regs [32];

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= 5'd0;
        end else begin
            pc <= pc + 5'd4;
        end
    end

    always_comb begin
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_op     = 3'b000;
        unique case (1'b1)
            (opcode == OP_RTYPE): begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                alu_op    = 3'b010;
            end
            (opcode == OP_ADDI): begin
                alu_src   = 1'b1;
                reg_write = 1'b1;
            end
            (opcode == OP_LW): begin
                alu_src    = 1'b1;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            (opcode == OP_SW): begin
                alu_src = 1'b1;
            end
            (opcode == OP_BEQ): begin
                alu_op = 3'b001;
            end
            default: begin
            end
        endcase
    end

    assign wr_addr = reg_dst ? rd : rt;
    assign wr_en   = reg_write && (wr_addr != 5'd0);

    // Reset wins over a same-cycle write; entry 0 is never written.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data1 = (rs == 5'd0) ? 32'd0 : regs[rs];
    assign rd_data2 = (rt == 5'd0) ? 32'd0 : regs[rt];

endmodule

// File: tb/tb_core_ctrl_regfile.sv
// Directed self-checking bench for core_ctrl_regfile.
// Register reads use opcode 111111 so they never write.
module tb_core_ctrl_regfile;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic [31:0] wr_data;
    logic [4:0]  pc;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic        reg_dst;
    logic        mem_to_reg;
    logic [2:0]  alu_op;
    logic        alu_src;
    logic        reg_write;

    int          checks = 0;
    int          errors = 0;
    logic [4:0]  pc_m;

    core_ctrl_regfile dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .wr_data    (wr_data),
        .pc         (pc),
        .rd_data1   (rd_data1),
        .rd_data2   (rd_data2),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_op     (alu_op),
        .alu_src    (alu_src),
        .reg_write  (reg_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        pc_m = rst_n ? pc_m + 5'd4 : 5'd0;
        #1;
    endtask

    task automatic rd_regs(input logic [4:0] a, input logic [4:0] b);
        instr = {6'h3f, a, b, 16'h0000};
        #1;
    endtask

    task automatic chk_ctrl(input string tag, input logic [6:0] exp);
        chk(tag, {25'd0, reg_dst, alu_src, mem_to_reg, reg_write, alu_op},
            {25'd0, exp});
    endtask

    initial begin
        rst_n   = 1'b0;
        instr   = 32'hFC00_0000;
        wr_data = 32'd0;
        pc_m    = 5'd0;

        // 1: reset and PC wrap
        step();
        chk("pc_rst0", {27'd0, pc}, 32'd0);
        step();
        chk("pc_rst1", {27'd0, pc}, 32'd0);
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk($sformatf("pc_seq%0d", i), {27'd0, pc}, (4 * i) % 32);
        end
        rd_regs(5'd1, 5'd31);
        chk("rst_r1", rd_data1, 32'd0);
        chk("rst_r31", rd_data2, 32'd0);

        // 2: R-type add $3,$1,$2
        instr   = 32'h0022_1820;
        wr_data = 32'hDEAD_BEEF;
        #1;
        chk_ctrl("ctrl_rtype", {1'b1, 1'b0, 1'b0, 1'b1, 3'b010});
        step();
        rd_regs(5'd3, 5'd3);
        chk("rtype_r3a", rd_data1, 32'hDEAD_BEEF);
        chk("rtype_r3b", rd_data2, 32'hDEAD_BEEF);

        // 3: addi $5,$0,7 -> writes rt
        instr   = 32'h2005_0007;
        wr_data = 32'd7;
        #1;
        chk_ctrl("ctrl_addi", {1'b0, 1'b1, 1'b0, 1'b1, 3'b000});
        step();
        rd_regs(5'd5, 5'd7);
        chk("addi_r5", rd_data1, 32'd7);
        chk("addi_r7", rd_data2, 32'd0);

        // lw and beq decodes
        instr = 32'h8C00_0000;
        #1;
        chk_ctrl("ctrl_lw", {1'b0, 1'b1, 1'b1, 1'b1, 3'b000});
        instr = 32'h1000_0000;
        #1;
        chk_ctrl("ctrl_beq", {1'b0, 1'b0, 1'b0, 1'b0, 3'b001});

        // 4: rd=0 discarded
        instr   = 32'h0022_0020;
        wr_data = 32'hFFFF_FFFF;
        step();
        rd_regs(5'd0, 5'd5);
        chk("r0_zero", rd_data1, 32'd0);
        chk("r0_r5", rd_data2, 32'd7);

        instr   = 32'hAC00_0000;
        wr_data = 32'h1234_5678;
        #1;
        chk_ctrl("ctrl_sw", {1'b0, 1'b1, 1'b0, 1'b0, 3'b000});
        step();
        instr = 32'hAC03_0000;
        step();
        rd_regs(5'd3, 5'd0);
        chk("sw_r3", rd_data1, 32'hDEAD_BEEF);
        chk("sw_r0", rd_data2, 32'd0);

        instr = {6'h3f, 5'd5, 5'd5, 5'd5, 11'h020};
        #1;
        chk_ctrl("ctrl_ill", 7'd0);
        step();
        rd_regs(5'd5, 5'd3);
        chk("ill_r5", rd_data1, 32'd7);
        chk("ill_r3", rd_data2, 32'hDEAD_BEEF);

        // 5: read-during-write, both ports on the target
        instr   = 32'h2004_0000;
        wr_data = 32'h11;
        step();
        instr   = 32'h0084_2020;
        wr_data = 32'h22;
        #1;
        chk("rdw_old1", rd_data1, 32'h11);
        chk("rdw_old2", rd_data2, 32'h11);
        step();
        chk("rdw_new1", rd_data1, 32'h22);
        chk("rdw_new2", rd_data2, 32'h22);
        rd_regs(5'd0, 5'd0);

        // 6: mid-run reset at pc=12
        for (int i = 0; i < 8 && pc_m != 5'd12; i++) begin
            step();
        end
        chk("mid_pc12", {27'd0, pc}, 32'd12);
        rd_regs(5'd3, 5'd0);
        chk("mid_r3_pre", rd_data1, 32'hDEAD_BEEF);
        rst_n   = 1'b0;
        instr   = 32'h0022_3020;
        wr_data = 32'h55;
        step();
        rst_n = 1'b1;
        rd_regs(5'd3, 5'd6);
        chk("mid_pc0", {27'd0, pc}, 32'd0);
        chk("mid_r3", rd_data1, 32'd0);
        chk("mid_r6", rd_data2, 32'd0);
        step();
        chk("mid_pc4", {27'd0, pc}, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/core_ctrl_regfile.md
# core_ctrl_regfile

Sequential heart of the single-cycle 32-bit processor: a 5-bit program counter, the main control decoder and a 32×32 register file in one block. It drives the instruction-memory address, decodes the fetched instruction into datapath controls, and supplies operands to the ALU. It accepts write-back data from the MemToReg mux outside the block.

## Interface
Parameters: none. Widths are fixed.

- `clk`  in  1  single system clock; all state updates on the rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `instr`  in  32  instruction fetched at `pc`
- `wr_data`  in  32  write-back data for the destination register
- `pc`  out  5  instruction-memory address
- `rd_data1`  out  32  register[`instr[25:21]`]
- `rd_data2`  out  32  register[`instr[20:16]`]
- `reg_dst`  out  1  destination select: 1 = `instr[15:11]`, 0 = `instr[20:16]`
- `mem_to_reg`  out  1  write-back source select for the external mux
- `alu_op`  out  3  ALU-control class code
- `alu_src`  out  1  ALU B operand select: 1 = immediate, 0 = `rd_data2`
- `reg_write`  out  1  register-file write enable, also exported

## Operation
- **PC**
  - 5-bit register.
  - Each cycle when not in reset: `pc <= pc + 4`, wrapping modulo 32, so 28 is followed by 0.
  - There is no branch or jump input.
- **Control decoder**
  - Purely combinational on `instr[31:26]`.
  - R-type (000000): reg_dst=1, alu_src=0, mem_to_reg=0, reg_write=1, alu_op=010.
  - addi (001000): reg_dst=0, alu_src=1, mem_to_reg=0, reg_write=1, alu_op=000.
  - lw (100011): reg_dst=0, alu_src=1, mem_to_reg=1, reg_write=1, alu_op=000.
  - sw (101011): reg_dst=0, alu_src=1, mem_to_reg=0, reg_write=0, alu_op=000.
  - beq (000100): reg_dst=0, alu_src=0, mem_to_reg=0, reg_write=0, alu_op=001.
  - Any other opcode: all outputs 0. No register state changes.
- **Register file**
  - 32 entries × 32 bits.
  - Two combinational read ports addressed by `instr[25:21]` and `instr[20:16]`.
  - One write port. Address = `reg_dst ? instr[15:11] : instr[20:16]`, data = `wr_data`.
  - Write occurs on the rising edge when `reg_write`=1.
  - Register 0 always reads 0. Writes to register 0 are discarded.

## Timing
- **Reset**
  - When `rst_n`=0 at a rising edge, `pc` becomes 0 and all 32 registers become 0.
  - Reset overrides any write pending in the same cycle.
  - Reset asserted mid-program takes effect on the next edge. Execution restarts at `pc`=0 with a cleared register file.
- **PC latency**
  - `pc` changes only on clock edges. One instruction per cycle.
- **Decode and read latency**
  - Control outputs and `rd_data1`/`rd_data2` are combinational from `instr` and register state.
  - Zero-cycle latency; they settle within the same cycle.
- **Write latency**
  - A write becomes visible on the read ports in the cycle after the edge that performs it.
- **Read-during-write**
  - Reading the register being written in the same cycle returns the old value. There is no internal bypass.
- **Simultaneous events**
  - Both read ports may address the same register, including the write target. Both return the identical (old) value.

## Test plan
1. **Reset and PC sequence.** Hold `rst_n`=0 for 2 cycles, then release.
   - During reset: `pc`=0.
   - After release: `pc` steps 0,4,8,…,28,0 (wrap).
   - Reading registers 1 and 31 returns 0.
2. **R-type write.** `instr`=0x00221820 (add $3,$1,$2), `wr_data`=0xDEADBEEF for one edge.
   - Same cycle: reg_dst=1, reg_write=1, alu_op=010, alu_src=0, mem_to_reg=0.
   - Next cycle, `instr` with rs=3: `rd_data1`=0xDEADBEEF.
3. **I-type destination.** `instr`=0x20050007 (addi $5,$0,7), `wr_data`=7.
   - alu_src=1, reg_dst=0.
   - Register 5 = 7 and register 7 unchanged.
4. **Register 0 and no-write opcodes.**
   - R-type with rd=0 and `wr_data`=0xFFFFFFFF: register 0 still reads 0.
   - sw (0xAC000000) and opcode 111111: reg_write=0, all registers unchanged; for 111111 every control output is 0.
5. **Read-during-write.** Register 4=0x11, then write 0x22 to register 4 while rs=4.
   - `rd_data1`=0x11 during that cycle, 0x22 the following cycle.
6. **Mid-run reset.** Assert `rst_n`=0 when `pc`=12 and register 3 is nonzero.
   - Next edge: `pc`=0, register 3=0.
   - A write requested in the reset cycle does not occur.
